// File: rtl/icg_enable_ctrl.sv
// rtl/icg_enable_ctrl.sv - enable-side controller for a positive-edge ICG cell
//
// Watches block activity and decides when the downstream clock may be gated.
// E is a flop output driving the ICG E pin directly. Because E only ever
// changes on a CLK rising edge and the ICG latch is transparent while CLK is
// low, E is settled long before capture and cannot glitch the gated clock.
// Wake-up uses a four-phase WAKE_REQ/WAKE_ACK handshake. TE forces the clock
// running for scan.
//
// Ports:
//   CLK       in   ungated always-on clock, rising edge
//   RST       in   asynchronous active-high reset
//   BUSY      in   gated-domain activity, synchronous to CLK
//   WAKE_REQ  in   four-phase wake request, held until WAKE_ACK=1
//   TE        in   test/scan enable, forces the clock ungated
//   E         out  registered enable to the ICG E pin
//   WAKE_ACK  out  registered wake acknowledge
//   GATED     out  registered status, 1 while the clock is gated
//
// Parameters:
//   IDLE_CYCLES  consecutive idle samples before gating (>= 1)
//   WAKE_CYCLES  cycles E is held high in WAKE before returning to RUN (>= 1)
//   CNT_W        counter width, 2**CNT_W > max(IDLE_CYCLES, WAKE_CYCLES)

module icg_enable_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic BUSY,
  input  logic WAKE_REQ,
  input  logic TE,
  output logic E,
  output logic WAKE_ACK,
  output logic GATED
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_OFF  = 2'd1,
    ST_WAKE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             act;
  logic             e_nxt;
  logic             ack_nxt;
  logic             gated_nxt;

  // A pending wake request counts as activity, so the idle counter stays
  // cleared for as long as WAKE_REQ is held in RUN.
  assign act = BUSY | WAKE_REQ;

  // Next-state and counter logic. The single counter is shared between the
  // idle count (RUN) and the wake hold (WAKE); it is cleared on every state
  // change and only ever compared against its own limit, so it never wraps.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;

    case (state)
      ST_RUN: begin
        if (act) begin
          // Activity on the threshold cycle still wins over gating.
          cnt_nxt = CNT_ZERO;
        end else if (cnt == IDLE_LAST) begin
          state_nxt = ST_OFF;
          cnt_nxt   = CNT_ZERO;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      ST_OFF: begin
        if (act) begin
          state_nxt = ST_WAKE;
          cnt_nxt   = CNT_ZERO;
        end
      end

      ST_WAKE: begin
        // Not abortable: activity dropping here still completes to RUN.
        if (cnt == WAKE_LAST) begin
          state_nxt = ST_RUN;
          cnt_nxt   = CNT_ZERO;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      default: begin
        state_nxt = ST_RUN;
        cnt_nxt   = CNT_ZERO;
      end
    endcase

    // Scan override: run the clock and restart the idle count afterwards.
    if (TE) begin
      state_nxt = ST_RUN;
      cnt_nxt   = CNT_ZERO;
    end
  end

  // Output values are derived from the next state so that every output is a
  // flop and still lines up with the state it describes.
  always_comb begin
    e_nxt     = (state_nxt != ST_OFF);
    gated_nxt = (state_nxt == ST_OFF);
    ack_nxt   = WAKE_REQ & (state_nxt == ST_RUN);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_RUN;
      cnt      <= CNT_ZERO;
      E        <= 1'b1;
      WAKE_ACK <= 1'b0;
      GATED    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      E        <= e_nxt;
      WAKE_ACK <= ack_nxt;
      GATED    <= gated_nxt;
    end
  end

  // Unknown activity inputs would make the gating decision meaningless.
  a_inputs_known: assert property (
    @(posedge CLK) disable iff (RST) !$isunknown({BUSY, WAKE_REQ, TE})
  );

endmodule

// File: tb/tb_icg_enable_ctrl.sv
// tb/tb_icg_enable_ctrl.sv - self-checking bench for icg_enable_ctrl

module tb_icg_enable_ctrl;

  localparam int IDLE = 4;
  localparam int WAKE = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic BUSY = 1'b0;
  logic WAKE_REQ = 1'b0;
  logic TE = 1'b0;
  logic E;
  logic WAKE_ACK;
  logic GATED;

  int total = 0;
  int bad = 0;

  icg_enable_ctrl #(
    .IDLE_CYCLES(IDLE),
    .WAKE_CYCLES(WAKE),
    .CNT_W(8)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .BUSY(BUSY),
    .WAKE_REQ(WAKE_REQ),
    .TE(TE),
    .E(E),
    .WAKE_ACK(WAKE_ACK),
    .GATED(GATED)
  );

  always #5 CLK = ~CLK;

  // E may only move on a rising CLK edge (reset aside).
  time last_pos = 0;
  always @(posedge CLK) last_pos = $time;
  always @(E) begin
    if (!RST && $time > 0) begin
      total++;
      if ($time != last_pos) begin
        bad++;
        $display("FAIL e_edge_only: E=%b changed at t=%0t, last rising edge t=%0t", E, $time, last_pos);
      end
    end
  end

  // Reference model: 0=run, 1=off, 2=wake.
  int m_st = 0;
  int m_idle = 0;
  int m_wake = 0;
  logic [2:0] exp_q[$];

  task automatic model_reset();
    m_st = 0;
    m_idle = 0;
    m_wake = 0;
  endtask

  // Predict {E, WAKE_ACK, GATED} for the coming edge, push it, clock, compare.
  task automatic cycle();
    int n_st, n_idle, n_wake;
    logic a;
    logic [2:0] want, got;
    a = BUSY | WAKE_REQ;
    n_st = m_st; n_idle = m_idle; n_wake = m_wake;
    if (TE) begin
      n_st = 0; n_idle = 0; n_wake = 0;
    end else if (m_st == 0) begin
      n_idle = a ? 0 : m_idle + 1;
      if (n_idle == IDLE) begin
        n_st = 1; n_idle = 0;
      end
    end else if (m_st == 1) begin
      if (a) begin
        n_st = 2; n_wake = 0;
      end
    end else begin
      n_wake = m_wake + 1;
      if (n_wake == WAKE) begin
        n_st = 0; n_idle = 0; n_wake = 0;
      end
    end
    exp_q.push_back({n_st != 1, WAKE_REQ && (n_st == 0), n_st == 1});
    @(posedge CLK);
    #1;
    m_st = n_st; m_idle = n_idle; m_wake = n_wake;
    want = exp_q.pop_front();
    got = {E, WAKE_ACK, GATED};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL scoreboard: {E,ACK,GATED}=%b want %b at t=%0t", got, want, $time);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; BUSY = 1'b0; WAKE_REQ = 1'b0; TE = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    model_reset();
    total++;
    if ({E, WAKE_ACK, GATED} !== 3'b100) begin
      bad++;
      $display("FAIL reset_vals: {E,ACK,GATED}=%b want 100", {E, WAKE_ACK, GATED});
    end
    repeat (2) cycle();
    // Reset mid-count, between edges.
    #3 RST = 1'b1;
    #1;
    total++;
    if ({E, GATED} !== 2'b10) begin
      bad++;
      $display("FAIL reset_midcount: {E,GATED}=%b want 10", {E, GATED});
    end
    @(posedge CLK);
    #1 RST = 1'b0;
    model_reset();
    repeat (IDLE - 1) cycle();
    total++;
    if (E !== 1'b1) begin
      bad++;
      $display("FAIL idle_before_thresh: E=%b want 1", E);
    end
    cycle();
    total++;
    if ({E, GATED} !== 2'b01) begin
      bad++;
      $display("FAIL gate_on_4th: {E,GATED}=%b want 01", {E, GATED});
    end
    repeat (5) cycle();
    total++;
    if (E !== 1'b0) begin
      bad++;
      $display("FAIL stay_gated: E=%b want 0", E);
    end
    // Asynchronous reset from OFF restores the clock at once.
    #3 RST = 1'b1;
    #1;
    total++;
    if ({E, WAKE_ACK, GATED} !== 3'b100) begin
      bad++;
      $display("FAIL reset_from_off: {E,ACK,GATED}=%b want 100", {E, WAKE_ACK, GATED});
    end
    @(posedge CLK);
    #1 RST = 1'b0;
    model_reset();
    repeat (IDLE) cycle();
  endtask

  task automatic test_threshold();
    RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    model_reset();
    BUSY = 1'b0;
    repeat (IDLE - 1) cycle();
    BUSY = 1'b1;
    cycle();
    BUSY = 1'b0;
    total++;
    if (E !== 1'b1) begin
      bad++;
      $display("FAIL thresh_act_wins: E=%b want 1", E);
    end
    repeat (IDLE - 1) cycle();
    total++;
    if (E !== 1'b1) begin
      bad++;
      $display("FAIL thresh_recount: E=%b want 1", E);
    end
    cycle();
    total++;
    if ({E, GATED} !== 2'b01) begin
      bad++;
      $display("FAIL thresh_gate: {E,GATED}=%b want 01", {E, GATED});
    end
  endtask

  task automatic test_wake_handshake();
    WAKE_REQ = 1'b1;
    cycle();
    total++;
    if ({E, WAKE_ACK, GATED} !== 3'b100) begin
      bad++;
      $display("FAIL wake_e_rise: {E,ACK,GATED}=%b want 100", {E, WAKE_ACK, GATED});
    end
    repeat (WAKE - 1) cycle();
    total++;
    if (WAKE_ACK !== 1'b0) begin
      bad++;
      $display("FAIL wake_ack_early: ACK=%b want 0", WAKE_ACK);
    end
    cycle();
    total++;
    if (WAKE_ACK !== 1'b1) begin
      bad++;
      $display("FAIL wake_ack_rise: ACK=%b want 1", WAKE_ACK);
    end
    repeat (3 * IDLE) cycle();
    total++;
    if ({E, WAKE_ACK} !== 2'b11) begin
      bad++;
      $display("FAIL wake_no_gate_req: {E,ACK}=%b want 11", {E, WAKE_ACK});
    end
    WAKE_REQ = 1'b0;
    cycle();
    total++;
    if ({E, WAKE_ACK} !== 2'b10) begin
      bad++;
      $display("FAIL wake_ack_fall: {E,ACK}=%b want 10", {E, WAKE_ACK});
    end
    repeat (IDLE - 2) cycle();
    total++;
    if (E !== 1'b1) begin
      bad++;
      $display("FAIL wake_regate_early: E=%b want 1", E);
    end
    cycle();
    total++;
    if (E !== 1'b0) begin
      bad++;
      $display("FAIL wake_regate: E=%b want 0", E);
    end
  endtask

  task automatic test_busy_wake();
    int acks = 0;
    BUSY = 1'b1;
    cycle();
    BUSY = 1'b0;
    total++;
    if ({E, GATED} !== 2'b10) begin
      bad++;
      $display("FAIL busy_wake_e: {E,GATED}=%b want 10", {E, GATED});
    end
    for (int i = 0; i < WAKE + IDLE; i++) begin
      cycle();
      if (WAKE_ACK) acks++;
    end
    total++;
    if (E !== 1'b0 || acks != 0) begin
      bad++;
      $display("FAIL busy_wake_regate: E=%b acks=%0d want E=0 acks=0", E, acks);
    end
  endtask

  task automatic test_te();
    TE = 1'b1;
    cycle();
    total++;
    if ({E, GATED} !== 2'b10) begin
      bad++;
      $display("FAIL te_ungate: {E,GATED}=%b want 10", {E, GATED});
    end
    repeat (10) cycle();
    total++;
    if (E !== 1'b1) begin
      bad++;
      $display("FAIL te_hold: E=%b want 1", E);
    end
    TE = 1'b0;
    repeat (IDLE - 1) cycle();
    total++;
    if (E !== 1'b1) begin
      bad++;
      $display("FAIL te_release_early: E=%b want 1", E);
    end
    cycle();
    total++;
    if (E !== 1'b0) begin
      bad++;
      $display("FAIL te_release_gate: E=%b want 0", E);
    end
  endtask

  task automatic test_random();
    logic prev_e, req_s;
    for (int i = 0; i < 600; i++) begin
      BUSY = ($urandom_range(0, 9) < 2);
      TE = ($urandom_range(0, 39) == 0);
      if (!WAKE_REQ && !WAKE_ACK && $urandom_range(0, 11) == 0) WAKE_REQ = 1'b1;
      else if (WAKE_REQ && WAKE_ACK && $urandom_range(0, 1) == 0) WAKE_REQ = 1'b0;
      prev_e = E;
      req_s = WAKE_REQ;
      cycle();
      total++;
      if (GATED !== ~E) begin
        bad++;
        $display("FAIL rnd_gated_not_e: GATED=%b E=%b", GATED, E);
      end
      total++;
      if (WAKE_ACK && !E) begin
        bad++;
        $display("FAIL rnd_ack_implies_e: ACK=%b E=%b", WAKE_ACK, E);
      end
      total++;
      if (prev_e && req_s && E !== 1'b1) begin
        bad++;
        $display("FAIL rnd_no_gate_on_req: E=%b want 1", E);
      end
    end
    BUSY = 1'b0;
    TE = 1'b0;
    WAKE_REQ = 1'b0;
    repeat (2) cycle();
  endtask

  initial begin
    test_reset();
    test_threshold();
    test_wake_handshake();
    test_busy_wake();
    test_te();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
